// File: rtl/timer_bus_pkg.sv
// Shared types and constants for the timer control master and its register bus.
package timer_bus_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned WD_MARGIN_DEF  = 16;
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORT   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ERR     = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    TCM_IDLE     = 3'd0,
    TCM_WR_TGT   = 3'd1,
    TCM_VERIFY   = 3'd2,
    TCM_WR_START = 3'd3,
    TCM_WAIT     = 3'd4,
    TCM_RD_STAT  = 3'd5,
    TCM_STOP     = 3'd6,
    TCM_RESP     = 3'd7
  } tcm_state_e;

endpackage

// File: rtl/timer_ctrl_master_if.sv
// Request/response handshake plus timer register strobes.
// AUTO_RELOAD_EN adds the req_repeat request field.
interface timer_ctrl_master_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_count;
  logic              req_abort;
`ifdef AUTO_RELOAD_EN
  logic [7:0]        req_repeat;
`endif
  logic              resp_valid;
  logic [1:0]        resp_status;
  logic              busy;
  logic              wr_ctrl_en;
  logic              wr_data_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_ctrl_en;
  logic              rd_data_en;
  logic [DATA_W-1:0] rd_ctrl_data;
  logic [DATA_W-1:0] rd_data_data;
  logic              timer_done;

  modport master (
`ifdef AUTO_RELOAD_EN
    input  req_repeat,
`endif
    input  req_valid, req_count, req_abort, rd_ctrl_data, rd_data_data, timer_done,
    output req_ready, resp_valid, resp_status, busy,
    output wr_ctrl_en, wr_data_en, wr_data, rd_ctrl_en, rd_data_en
  );

  modport slave (
`ifdef AUTO_RELOAD_EN
    output req_repeat,
`endif
    output req_valid, req_count, req_abort, rd_ctrl_data, rd_data_data, timer_done,
    input  req_ready, resp_valid, resp_status, busy,
    input  wr_ctrl_en, wr_data_en, wr_data, rd_ctrl_en, rd_data_en
  );
endinterface

// File: rtl/tcm_watchdog.sv
// Saturating WAIT-cycle counter; expired_o is high once more than limit_i cycles have elapsed.
module tcm_watchdog #(
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DATA_W:0] limit_i,
  output logic          expired_o
);
  localparam int unsigned CNT_W = DATA_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Compare against the next count so the flag lines up with the cycle it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d >= limit_i);
    end
  end

  assign expired_o = expired_q;
endmodule

// File: rtl/timer_ctrl_master.sv
// Bus initiator that programs the timer target, starts it and supervises completion.
// Optional AUTO_RELOAD_EN: repeats START req_repeat+1 times before a single response.
module timer_ctrl_master
  import timer_bus_pkg::*;
#(
  parameter int unsigned WD_MARGIN = WD_MARGIN_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  timer_ctrl_master_if.master bus
);
  localparam int unsigned LIM_W = DATA_W + 1;

  localparam logic [2:0] S_IDLE     = 3'(TCM_IDLE);
  localparam logic [2:0] S_WR_TGT   = 3'(TCM_WR_TGT);
  localparam logic [2:0] S_VERIFY   = 3'(TCM_VERIFY);
  localparam logic [2:0] S_WR_START = 3'(TCM_WR_START);
  localparam logic [2:0] S_WAIT     = 3'(TCM_WAIT);
  localparam logic [2:0] S_RD_STAT  = 3'(TCM_RD_STAT);
  localparam logic [2:0] S_STOP     = 3'(TCM_STOP);
  localparam logic [2:0] S_RESP     = 3'(TCM_RESP);

  localparam logic [DATA_W-1:0] START_WORD = DATA_W'(1) << CTRL_START_BIT;
  localparam logic [DATA_W-1:0] DONE_MASK  = DATA_W'(1) << CTRL_DONE_BIT;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  status_e           status_q, status_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic              wr_ctrl_en_q, wr_ctrl_en_d;
  logic              wr_data_en_q, wr_data_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_ctrl_en_q, rd_ctrl_en_d;
  logic              rd_data_en_q, rd_data_en_d;

  logic [LIM_W-1:0]  limit;
  logic              wd_expired;

`ifdef AUTO_RELOAD_EN
  logic [7:0]        rep_q, rep_d;
  logic [7:0]        iter_q, iter_d;
`endif

  // Limit is one bit wider than the count so count+margin never wraps.
  assign limit = LIM_W'(count_q) + LIM_W'(WD_MARGIN);

  tcm_watchdog #(.DATA_W(DATA_W)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == S_WR_START),
    .en_i      (state_q == S_WAIT),
    .limit_i   (limit),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    status_d = status_q;
`ifdef AUTO_RELOAD_EN
    rep_d    = rep_q;
    iter_d   = iter_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          count_d  = bus.req_count;
          status_d = ST_OK;
          state_d  = S_WR_TGT;
`ifdef AUTO_RELOAD_EN
          rep_d    = bus.req_repeat;
          iter_d   = '0;
`endif
        end
      end
      // A zero count still passes through here, but with its strobe suppressed.
      S_WR_TGT: begin
        if (count_q == '0) begin
          status_d = ST_ERR;
          state_d  = S_RESP;
        end else begin
          state_d  = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (bus.rd_data_data != count_q) begin
          status_d = ST_ERR;
          state_d  = S_RESP;
        end else begin
          state_d  = S_WR_START;
        end
      end
      S_WR_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.timer_done) begin
          state_d  = S_RD_STAT;
        end else if (bus.req_abort) begin
          status_d = ST_ABORT;
          state_d  = S_STOP;
        end else if (wd_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = S_STOP;
        end
      end
      S_RD_STAT: begin
        if ((bus.rd_ctrl_data & DONE_MASK) != '0) begin
          status_d = ST_OK;
          state_d  = S_RESP;
`ifdef AUTO_RELOAD_EN
          if (iter_q != rep_q) begin
            iter_d  = iter_q + 8'd1;
            state_d = S_WR_START;
          end
`endif
        end else begin
          status_d = ST_ERR;
          state_d  = S_RESP;
        end
      end
      S_STOP:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    resp_valid_d  = (state_d == S_RESP);
    resp_status_d = (state_d == S_RESP) ? status_d : ST_OK;
    wr_data_en_d  = (state_d == S_WR_TGT) && (count_d != '0);
    rd_data_en_d  = (state_d == S_VERIFY);
    wr_ctrl_en_d  = (state_d == S_WR_START) || (state_d == S_STOP);
    rd_ctrl_en_d  = (state_d == S_RD_STAT);
    wr_data_d     = '0;
    if (state_d == S_WR_TGT) begin
      wr_data_d = count_d;
    end else if (state_d == S_WR_START) begin
      wr_data_d = START_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      status_q      <= ST_OK;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      wr_ctrl_en_q  <= 1'b0;
      wr_data_en_q  <= 1'b0;
      wr_data_q     <= '0;
      rd_ctrl_en_q  <= 1'b0;
      rd_data_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      status_q      <= status_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      wr_ctrl_en_q  <= wr_ctrl_en_d;
      wr_data_en_q  <= wr_data_en_d;
      wr_data_q     <= wr_data_d;
      rd_ctrl_en_q  <= rd_ctrl_en_d;
      rd_data_en_q  <= rd_data_en_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q  <= '0;
      iter_q <= '0;
    end else begin
      rep_q  <= rep_d;
      iter_q <= iter_d;
    end
  end
`endif

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_status = resp_status_q;
  assign bus.wr_ctrl_en  = wr_ctrl_en_q;
  assign bus.wr_data_en  = wr_data_en_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_ctrl_en  = rd_ctrl_en_q;
  assign bus.rd_data_en  = rd_data_en_q;
endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master: timer peripheral model, reference model, monitor.
module tb_timer_ctrl_master;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WD_MARGIN = 16;
  localparam int unsigned NEVER     = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_master_if #(.DATA_W(DATA_W)) bus ();

  timer_ctrl_master #(.WD_MARGIN(WD_MARGIN), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  status;
    int unsigned lat;
    int unsigned count;
    int unsigned n_strobe;
    int unsigned n_start;
    int unsigned n_stop;
  } exp_t;
  exp_t sb_q[$];

  // Timer peripheral model: done rises cfg_delay cycles after the START strobe cycle.
  logic              run = 1'b0;
  logic [DATA_W-1:0] tgt = '0;
  int unsigned start_cyc = 0, cfg_delay = 1, cfg_abort_at = 0, acc_cyc_s = 0;
  bit cfg_never = 1'b1, cfg_corrupt = 1'b0, cfg_abort = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      if (bus.wr_data_en) begin
        tgt <= bus.wr_data;
        run <= 1'b0;
      end
      if (bus.wr_ctrl_en) begin
        run       <= bus.wr_data[0];
        start_cyc <= cyc;
      end
    end
  end

  assign bus.timer_done   = run && !cfg_never && (cyc >= start_cyc + cfg_delay);
  assign bus.req_abort    = cfg_abort && (cyc >= acc_cyc_s + cfg_abort_at);
  assign bus.rd_data_data = tgt ^ DATA_W'(cfg_corrupt);
  assign bus.rd_ctrl_data = DATA_W'({bus.timer_done, run});
`ifdef AUTO_RELOAD_EN
  assign bus.req_repeat   = 8'd0;
`endif

  // Reference: first WAIT cycle (1-based) on which each exit condition holds.
  function automatic exp_t model(int unsigned count, int unsigned delay, bit never,
                                 bit corrupt, bit abort_en, int unsigned abort_at);
    exp_t e;
    int unsigned wd, wa, wt;
    e.count   = count;
    e.n_start = 0;
    e.n_stop  = 0;
    if (count == 0) begin
      e.status = 2'd3; e.lat = 2; e.n_strobe = 0;
    end else if (corrupt) begin
      e.status = 2'd3; e.lat = 3; e.n_strobe = 2;
    end else begin
      wt = count + WD_MARGIN + 1;
      wd = never ? NEVER : delay;
      wa = !abort_en ? NEVER : ((abort_at >= 4) ? abort_at - 3 : 1);
      e.n_strobe = 4;
      e.n_start  = 1;
      if (wd <= wa && wd <= wt) begin
        e.status = 2'd0; e.lat = 3 + wd + 2;
      end else if (wa <= wt) begin
        e.status = 2'd1; e.lat = 3 + wa + 2; e.n_stop = 1;
      end else begin
        e.status = 2'd2; e.lat = 3 + wt + 2; e.n_stop = 1;
      end
    end
    return e;
  endfunction

  task automatic wait_ready(input string name);
    int unsigned n = 0;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk(name, 64'(bus.req_ready), 64'(1));
  endtask

  task automatic issue(input int unsigned count, input int unsigned delay, input bit never,
                       input bit corrupt, input bit abort_en, input int unsigned abort_at,
                       input bit track);
    wait_ready("ready_before_req");
    @(posedge clk); #1;
    cfg_delay    = delay;
    cfg_never    = never;
    cfg_corrupt  = corrupt;
    cfg_abort    = abort_en;
    cfg_abort_at = abort_at;
    acc_cyc_s    = cyc;
    if (track) sb_q.push_back(model(count, delay, never, corrupt, abort_en, abort_at));
    bus.req_count = DATA_W'(count);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    wait_ready("ready_after_req");
  endtask

  // Monitor: tracks each transaction from accept to response and scores it.
  bit mon_en = 1'b1;
  int unsigned m_acc = 0, m_strobes = 0, m_start = 0, m_stop = 0, m_max = 0, m_start_lat = 0;

  always @(negedge clk) begin
    int unsigned s;
    exp_t e;
    if (rst_n && mon_en) begin
      s = 32'(bus.wr_ctrl_en) + 32'(bus.wr_data_en) + 32'(bus.rd_ctrl_en) + 32'(bus.rd_data_en);
      if (bus.req_valid && bus.req_ready) begin
        m_acc = cyc; m_strobes = 0; m_start = 0; m_stop = 0; m_max = 0; m_start_lat = 0;
      end
      m_strobes += s;
      if (s > m_max) m_max = s;
      if (bus.wr_data_en)
        chk("wr_tgt_data", 64'(bus.wr_data), 64'((sb_q.size() != 0) ? sb_q[0].count : 0));
      if (bus.wr_ctrl_en) begin
        if (bus.wr_data == DATA_W'(1)) begin
          if (m_start == 0) m_start_lat = cyc - m_acc;
          m_start++;
        end else if (bus.wr_data == '0) begin
          m_stop++;
        end else begin
          chk("ctrl_wr_data", 64'(bus.wr_data), 64'(0));
        end
      end
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_valid), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("resp_status", 64'(bus.resp_status), 64'(e.status));
          chk("resp_latency", 64'(cyc - m_acc), 64'(e.lat));
          chk("strobe_count", 64'(m_strobes), 64'(e.n_strobe));
          chk("start_count", 64'(m_start), 64'(e.n_start));
          chk("stop_count", 64'(m_stop), 64'(e.n_stop));
          chk("strobe_excl", 64'(m_max <= 1), 64'(1));
          chk("resp_busy", 64'(bus.busy), 64'(1));
          if (e.n_start != 0) chk("start_latency", 64'(m_start_lat), 64'(3));
          if (e.n_stop != 0) chk("done_after_stop", 64'(bus.timer_done), 64'(0));
        end
      end
    end
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_status", 64'(bus.resp_status), 64'(0));
    chk("rst_strobes", 64'({bus.wr_ctrl_en, bus.wr_data_en, bus.rd_ctrl_en, bus.rd_data_en}), 64'(0));
    chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
    rst_n = 1'b1;

    issue(10, 10, 0, 0, 0, 0, 1);    // nominal OK
    issue(0, 1, 1, 0, 0, 0, 1);      // zero count -> ERR, no bus activity
    issue(100, 1, 1, 0, 1, 53, 1);   // abort on WAIT cycle 50
    issue(20, 1, 1, 0, 0, 0, 1);     // timeout on WAIT cycle 37
    issue(10, 10, 0, 0, 1, 13, 1);   // done and abort together -> OK
    issue(5, 22, 0, 0, 0, 0, 1);     // done on the last legal cycle
    issue(5, 23, 0, 0, 0, 0, 1);     // done one cycle late -> TIMEOUT
    issue(12, 5, 0, 0, 1, 1, 1);     // abort raised before WAIT
    issue(8, 4, 0, 1, 0, 0, 1);      // readback mismatch -> ERR

    for (int i = 0; i < 40; i++) begin
      int unsigned c, d, a;
      bit nv, cr, ab;
      c  = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 40);
      d  = $urandom_range(1, 70);
      nv = ($urandom % 4 == 0);
      cr = ($urandom % 10 == 0);
      ab = ($urandom % 3 == 0);
      a  = $urandom_range(0, 70);
      issue(c, d, nv, cr, ab, a, 1);
    end

    // Reset asserted while waiting on the timer.
    mon_en = 1'b0;
    wait_ready("ready_before_rst");
    @(posedge clk); #1;
    cfg_never = 1'b1; cfg_abort = 1'b0; cfg_corrupt = 1'b0;
    bus.req_count = DATA_W'(30);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 64'({bus.wr_ctrl_en, bus.wr_data_en, bus.rd_ctrl_en, bus.rd_data_en}), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'(1));
    chk("post_rst_busy", 64'(bus.busy), 64'(0));
    mon_en = 1'b1;

    issue(10, 10, 0, 0, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
